// File: rtl/axi_bridge_pkg.sv
// Shared types and helpers for the multi-port sram-like to AXI3 bridge.
// State encoding, AXI constants and the write-strobe decoder.
package axi_bridge_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_AR   = 3'd1,
    S_R    = 3'd2,
    S_W    = 3'd3,
    S_B    = 3'd4
  } state_t;

  localparam int ID_W = 4;
  localparam int ALEN_W = 4;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  // Size 3 is an illegal encoding: no lanes enabled.
  function automatic logic [3:0] wstrb_f(
    input logic [1:0] sz,
    input logic [1:0] a
  );
    logic [3:0] s;
    s = 4'b0000;
    unique case (sz)
      SIZE_BYTE: s = 4'b0001 << a;
      SIZE_HALF: s = 4'b0011 << {a[1], 1'b0};
      SIZE_WORD: s = 4'b1111;
      default:   s = 4'b0000;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: scans req starting at ptr, grants the first hit.
// The owner keeps and advances ptr.
module rr_arbiter #(
  parameter int N = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  always_comb begin
    logic found;
    int   j;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    j       = 0;
    if (en) begin
      for (int i = 0; i < N; i++) begin
        j = (int'(ptr) + i) % N;
        if (!found && req[j]) begin
          gnt[j]  = 1'b1;
          gnt_idx = IW'(j);
          found   = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/axi_multiport_bridge.sv
// N-port sram-like to AXI3 bridge, one transaction in flight at a time.
// Reads use INCR bursts of len+1 beats; writes are single-beat.
module axi_multiport_bridge
  import axi_bridge_pkg::*;
#(
  parameter int N_PORTS = 2,
  parameter int LEN_W   = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_PORTS-1:0]        req,
  input  logic [N_PORTS-1:0]        wr,
  input  logic [2*N_PORTS-1:0]      size,
  input  logic [32*N_PORTS-1:0]     addr,
  input  logic [32*N_PORTS-1:0]     wdata,
  input  logic [LEN_W*N_PORTS-1:0]  len,
  output logic [N_PORTS-1:0]        addr_ok,
  output logic [N_PORTS-1:0]        data_ok,
  output logic [31:0]               rdata,
  output logic                      rlast_o,
  output logic                      err,
  output logic [ID_W-1:0]           arid,
  output logic [31:0]               araddr,
  output logic [ALEN_W-1:0]         arlen,
  output logic [2:0]                arsize,
  output logic [1:0]                arburst,
  output logic [1:0]                arlock,
  output logic [3:0]                arcache,
  output logic [2:0]                arprot,
  output logic                      arvalid,
  input  logic                      arready,
  input  logic [ID_W-1:0]           rid,
  input  logic [31:0]               rdata_axi,
  input  logic [1:0]                rresp,
  input  logic                      rlast,
  input  logic                      rvalid,
  output logic                      rready,
  output logic [ID_W-1:0]           awid,
  output logic [31:0]               awaddr,
  output logic [ALEN_W-1:0]         awlen,
  output logic [2:0]                awsize,
  output logic [1:0]                awburst,
  output logic [1:0]                awlock,
  output logic [3:0]                awcache,
  output logic [2:0]                awprot,
  output logic                      awvalid,
  input  logic                      awready,
  output logic [ID_W-1:0]           wid,
  output logic [31:0]               wdata_axi,
  output logic [3:0]                wstrb,
  output logic                      wlast,
  output logic                      wvalid,
  input  logic                      wready,
  input  logic [ID_W-1:0]           bid,
  input  logic [1:0]                bresp,
  input  logic                      bvalid,
  output logic                      bready
);

  localparam int IW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  state_t            r_state;
  logic [IW-1:0]     r_ptr;
  logic [IW-1:0]     r_idx;
  logic [1:0]        r_size;
  logic [31:0]       r_addr;
  logic [31:0]       r_wdata;
  logic [LEN_W-1:0]  r_len;
  logic              r_aw_done;
  logic              r_w_done;

  state_t            w_state_n;
  logic              w_aw_done_n;
  logic              w_w_done_n;
  logic              w_en;
  logic              w_any;
  logic [N_PORTS-1:0] w_gnt;
  logic [IW-1:0]     w_gnt_idx;
  logic [IW-1:0]     w_ptr_n;
  logic              w_sel_wr;
  logic [1:0]        w_sel_size;
  logic [31:0]       w_sel_addr;
  logic [31:0]       w_sel_wdata;
  logic [LEN_W-1:0]  w_sel_len;
  logic [N_PORTS-1:0] w_onehot;
  logic              w_unused;

  // Grants are suppressed while reset is held so every output reads 0.
  assign w_en = (r_state == S_IDLE) && !reset;

  rr_arbiter #(
    .N  (N_PORTS),
    .IW (IW)
  ) u_arb (
    .req     (req),
    .ptr     (r_ptr),
    .en      (w_en),
    .gnt     (w_gnt),
    .gnt_idx (w_gnt_idx)
  );

  assign w_any       = |w_gnt;
  assign w_sel_wr    = wr[w_gnt_idx];
  assign w_sel_size  = size[w_gnt_idx*2 +: 2];
  assign w_sel_addr  = addr[w_gnt_idx*32 +: 32];
  assign w_sel_wdata = wdata[w_gnt_idx*32 +: 32];
  assign w_sel_len   = len[w_gnt_idx*LEN_W +: LEN_W];
  assign w_ptr_n     = (w_gnt_idx == IW'(N_PORTS - 1)) ?
                       '0 : w_gnt_idx + IW'(1);
  assign w_onehot    = N_PORTS'(1) << r_idx;
  assign w_unused    = ^{rid, bid};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_ptr     <= '0;
      r_idx     <= '0;
      r_size    <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_len     <= '0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_aw_done <= w_aw_done_n;
      r_w_done  <= w_w_done_n;
      if (w_any) begin
        r_ptr   <= w_ptr_n;
        r_idx   <= w_gnt_idx;
        r_size  <= w_sel_size;
        r_addr  <= w_sel_addr;
        r_wdata <= w_sel_wdata;
        r_len   <= w_sel_len;
      end
    end
  end

  always_comb begin
    w_state_n   = r_state;
    w_aw_done_n = r_aw_done;
    w_w_done_n  = r_w_done;
    unique case (r_state)
      S_IDLE: begin
        if (w_any) w_state_n = w_sel_wr ? S_W : S_AR;
      end
      S_AR: begin
        if (arready) w_state_n = S_R;
      end
      S_R: begin
        if (rvalid && rlast) w_state_n = S_IDLE;
      end
      S_W: begin
        // AW and W complete independently, in either order.
        if (awready) w_aw_done_n = 1'b1;
        if (wready)  w_w_done_n  = 1'b1;
        if (w_aw_done_n && w_w_done_n) begin
          w_state_n   = S_B;
          w_aw_done_n = 1'b0;
          w_w_done_n  = 1'b0;
        end
      end
      S_B: begin
        if (bvalid) w_state_n = S_IDLE;
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  always_comb begin
    addr_ok   = w_gnt;
    data_ok   = '0;
    rdata     = '0;
    rlast_o   = 1'b0;
    err       = 1'b0;
    arid      = '0;
    araddr    = '0;
    arlen     = '0;
    arsize    = '0;
    arburst   = '0;
    arlock    = '0;
    arcache   = '0;
    arprot    = '0;
    arvalid   = 1'b0;
    rready    = 1'b0;
    awid      = '0;
    awaddr    = '0;
    awlen     = '0;
    awsize    = '0;
    awburst   = '0;
    awlock    = '0;
    awcache   = '0;
    awprot    = '0;
    awvalid   = 1'b0;
    wid       = '0;
    wdata_axi = '0;
    wstrb     = '0;
    wlast     = 1'b0;
    wvalid    = 1'b0;
    bready    = 1'b0;
    unique case (r_state)
      S_IDLE: ;
      S_AR: begin
        arvalid = 1'b1;
        arid    = ID_W'(r_idx);
        araddr  = r_addr;
        arlen   = ALEN_W'(r_len);
        arsize  = {1'b0, r_size};
        arburst = BURST_INCR;
      end
      S_R: begin
        rready = 1'b1;
        if (rvalid) begin
          data_ok = w_onehot;
          rdata   = rdata_axi;
          rlast_o = rlast;
          err     = (rresp != RESP_OKAY);
        end
      end
      S_W: begin
        awvalid   = !r_aw_done;
        wvalid    = !r_w_done;
        awid      = ID_W'(r_idx);
        awaddr    = r_addr;
        awsize    = {1'b0, r_size};
        awburst   = BURST_INCR;
        wid       = ID_W'(r_idx);
        wdata_axi = r_wdata;
        wstrb     = wstrb_f(r_size, r_addr[1:0]);
        wlast     = 1'b1;
      end
      S_B: begin
        bready = 1'b1;
        if (bvalid) begin
          data_ok = w_onehot;
          err     = (bresp != RESP_OKAY);
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_axi_multiport_bridge.sv
// Bench for axi_multiport_bridge: directed table, corner sequences and
// randomized traffic against a transaction-level master/slave model.
module tb_axi_multiport_bridge;

  localparam int NP = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req, wr;
  logic [3:0]  size;
  logic [63:0] addr, wdata;
  logic [7:0]  len;
  logic [1:0]  addr_ok, data_ok;
  logic [31:0] rdata;
  logic        rlast_o, err;
  logic [3:0]  arid, arlen, arcache, awid, awlen, awcache, wid, rid, bid;
  logic [31:0] araddr, awaddr, wdata_axi, rdata_axi;
  logic [2:0]  arsize, arprot, awsize, awprot;
  logic [1:0]  arburst, arlock, awburst, awlock, rresp, bresp;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [3:0]  wstrb;

  axi_multiport_bridge #(.N_PORTS(NP), .LEN_W(4)) dut (
    .clk(clk), .reset(reset), .req(req), .wr(wr), .size(size),
    .addr(addr), .wdata(wdata), .len(len),
    .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata),
    .rlast_o(rlast_o), .err(err),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arlock(arlock), .arcache(arcache),
    .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata_axi(rdata_axi), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awlock(awlock), .awcache(awcache),
    .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata_axi(wdata_axi), .wstrb(wstrb), .wlast(wlast),
    .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  len;
  } rq_t;

  typedef struct {
    int          port;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  len;
    int          ar_lat;
    int          aw_lat;
    int          w_lat;
    int          gap;
    logic [1:0]  resp;
    int          exp_beats;
    logic [3:0]  exp_strb;
    logic        exp_err;
  } vec_t;

  int checks = 0;
  int errors = 0;

  rq_t q0[$];
  rq_t q1[$];

  // slave configuration
  int c_ar_lat, c_aw_lat, c_w_lat, c_b_lat, c_gap;
  logic [1:0] c_rresp, c_bresp;

  // slave state
  int s_ar_cnt, s_wr_cyc, s_b_cnt, s_beat;
  logic [3:0] s_rlen;
  bit s_rd_act, s_awd, s_wd, s_b_pend;

  // transaction-level reference model
  int  m_ptr, m_port, m_beats, m_last_beats;
  bit  m_busy, m_ar_done, m_aw_done, m_w_done;
  rq_t m_cur;
  logic [3:0] m_last_strb;
  logic m_last_err;
  int grant_log[$];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic int rr_pick(input logic [1:0] r, input int p);
    for (int i = 0; i < NP; i++)
      if (r[(p + i) % NP]) return (p + i) % NP;
    return 0;
  endfunction

  function automatic logic [3:0] exp_strb(input logic [1:0] s,
                                          input logic [1:0] a);
    case (s)
      2'd0: return 4'b0001 << a;
      2'd1: return a[1] ? 4'b1100 : 4'b0011;
      2'd2: return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  task automatic clear_env();
    q0.delete(); q1.delete();
    s_ar_cnt = 0; s_wr_cyc = 0; s_b_cnt = 0; s_beat = 0; s_rlen = 0;
    s_rd_act = 0; s_awd = 0; s_wd = 0; s_b_pend = 0;
    m_ptr = 0; m_busy = 0; m_ar_done = 0; m_aw_done = 0; m_w_done = 0;
    m_beats = 0;
    req = '0; wr = '0; size = '0; addr = '0; wdata = '0; len = '0;
    arready = 0; rvalid = 0; rlast = 0; rresp = 0; rdata_axi = 0;
    rid = 0; awready = 0; wready = 0; bvalid = 0; bresp = 0; bid = 0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, {addr_ok, data_ok, rlast_o, err, arvalid, rready,
        awvalid, wvalid, wlast, bready}, 0);
    chk({tag, "_rd"}, {rdata, araddr}, 0);
    chk({tag, "_wr"}, {awaddr, wdata_axi}, 0);
    chk({tag, "_fld"}, {arid, arlen, arsize, arburst, awid, awlen,
        awsize, awburst, wid, wstrb}, 0);
  endtask

  task automatic tick();
    logic [1:0] exp_ao, exp_do;
    int w;
    @(negedge clk);
    req = '0; wr = '0; size = '0; addr = '0; wdata = '0; len = '0;
    if (q0.size() > 0) begin
      req[0] = 1; wr[0] = q0[0].wr; size[1:0] = q0[0].size;
      addr[31:0] = q0[0].addr; wdata[31:0] = q0[0].wdata;
      len[3:0] = q0[0].len;
    end
    if (q1.size() > 0) begin
      req[1] = 1; wr[1] = q1[0].wr; size[3:2] = q1[0].size;
      addr[63:32] = q1[0].addr; wdata[63:32] = q1[0].wdata;
      len[7:4] = q1[0].len;
    end
    arready = arvalid && (s_ar_cnt >= c_ar_lat);
    rvalid = s_rd_act && (int'($urandom_range(99)) >= c_gap);
    rdata_axi = $urandom;
    rlast = (s_beat == int'(s_rlen));
    rresp = c_rresp;
    awready = awvalid && (s_wr_cyc >= c_aw_lat);
    wready = wvalid && (s_wr_cyc >= c_w_lat);
    bvalid = s_b_pend && (s_b_cnt >= c_b_lat);
    bresp = c_bresp;
    #1;
    exp_ao = 0;
    w = rr_pick(req, m_ptr);
    if (!m_busy && req != 0) exp_ao = 2'b01 << w;
    chk("addr_ok", addr_ok, exp_ao);
    exp_do = 0;
    if (m_busy && !m_cur.wr && s_rd_act && rvalid) exp_do = 2'b01 << m_port;
    if (m_busy && m_cur.wr && bvalid) exp_do = 2'b01 << m_port;
    chk("data_ok", data_ok, exp_do);
    chk("arvalid", arvalid, m_busy && !m_cur.wr && !m_ar_done);
    chk("rready", rready, m_busy && !m_cur.wr && m_ar_done);
    chk("awvalid", awvalid, m_busy && m_cur.wr && !m_aw_done);
    chk("wvalid", wvalid, m_busy && m_cur.wr && !m_w_done);
    chk("bready", bready, m_busy && m_cur.wr && m_aw_done && m_w_done);
    if (exp_do != 0 && !m_cur.wr) begin
      chk("rdata", rdata, rdata_axi);
      chk("rlast_o", rlast_o, rlast);
      chk("rerr", err, rresp != 2'b00);
      m_beats++;
      m_last_err = err;
      if (rlast) begin m_busy = 0; m_last_beats = m_beats; end
    end
    if (exp_do != 0 && m_cur.wr) begin
      chk("berr", err, bresp != 2'b00);
      m_beats++;
      m_last_err = err;
      m_busy = 0;
      m_last_beats = m_beats;
    end
    if (arvalid && arready) begin
      chk("arid", arid, m_port);
      chk("araddr", araddr, m_cur.addr);
      chk("arlen", arlen, m_cur.len);
      chk("arsize", arsize, {1'b0, m_cur.size});
      chk("arburst", arburst, 2'b01);
      chk("ar_zero", {arlock, arcache, arprot}, 0);
      m_ar_done = 1;
      s_rd_act = 1; s_beat = 0; s_rlen = arlen; s_ar_cnt = 0;
    end else if (arvalid) s_ar_cnt++;
    if (rvalid && rready) begin
      if (rlast) s_rd_act = 0;
      s_beat++;
    end
    if (awvalid && awready) begin
      chk("awid", awid, m_port);
      chk("awaddr", awaddr, m_cur.addr);
      chk("awlen", awlen, 0);
      chk("awsize", awsize, {1'b0, m_cur.size});
      chk("awburst", awburst, 2'b01);
      m_aw_done = 1; s_awd = 1;
    end
    if (wvalid && wready) begin
      chk("wid", wid, m_port);
      chk("wdata", wdata_axi, m_cur.wdata);
      chk("wstrb", wstrb, exp_strb(m_cur.size, m_cur.addr[1:0]));
      chk("wlast", wlast, 1);
      m_last_strb = wstrb;
      m_w_done = 1; s_wd = 1;
    end
    if (awvalid || wvalid) s_wr_cyc++;
    if (bvalid && bready) begin
      s_b_pend = 0; s_awd = 0; s_wd = 0; s_wr_cyc = 0;
    end else if (s_b_pend) s_b_cnt++;
    if (s_awd && s_wd && !s_b_pend) begin s_b_pend = 1; s_b_cnt = 0; end
    if (exp_ao != 0 && addr_ok == exp_ao) begin
      m_cur = (w == 0) ? q0.pop_front() : q1.pop_front();
      m_port = w; m_busy = 1; m_beats = 0;
      m_ar_done = 0; m_aw_done = 0; m_w_done = 0;
      m_ptr = (w + 1) % NP;
      grant_log.push_back(w);
    end
  endtask

  function automatic bit env_idle();
    return !m_busy && q0.size() == 0 && q1.size() == 0 &&
           !s_rd_act && !s_b_pend;
  endfunction

  task automatic run_idle(input string nm);
    int n;
    n = 0;
    while (!env_idle() && n < 2000) begin tick(); n++; end
    if (!env_idle()) begin
      checks++; errors++;
      $display("FAIL %s timeout actual=busy required=idle", nm);
      clear_env();
    end
  endtask

  task automatic push(input int p, input rq_t r);
    if (p == 0) q0.push_back(r); else q1.push_back(r);
  endtask

  vec_t tv[9];

  initial begin
    rq_t r;
    int p0, n;
    clear_env();
    c_ar_lat = 0; c_aw_lat = 0; c_w_lat = 0; c_b_lat = 0; c_gap = 0;
    c_rresp = 0; c_bresp = 0;
    reset = 1;
    #1;
    chk_zero("reset");
    repeat (2) @(negedge clk);
    reset = 0;

    tv[0] = '{0, 1'b0, 2'd2, 32'h1FC0_0000, 32'h0, 4'd0,
              2, 0, 0, 0, 2'b00, 1, 4'h0, 1'b0};
    tv[1] = '{1, 1'b0, 2'd2, 32'h0000_1000, 32'h0, 4'd7,
              0, 0, 0, 40, 2'b00, 8, 4'h0, 1'b0};
    tv[2] = '{0, 1'b1, 2'd0, 32'h8000_0003, 32'hAABB_CCDD, 4'd0,
              0, 3, 0, 0, 2'b00, 1, 4'b1000, 1'b0};
    tv[3] = '{0, 1'b1, 2'd1, 32'h8000_0002, 32'h1122_3344, 4'd0,
              0, 3, 0, 0, 2'b00, 1, 4'b1100, 1'b0};
    tv[4] = '{1, 1'b1, 2'd2, 32'h1234_5678, 32'hDEAD_BEEF, 4'd0,
              0, 1, 1, 0, 2'b10, 1, 4'b1111, 1'b1};
    tv[5] = '{0, 1'b0, 2'd2, 32'h0000_2000, 32'h0, 4'd3,
              1, 0, 0, 20, 2'b11, 4, 4'h0, 1'b1};
    tv[6] = '{1, 1'b1, 2'd3, 32'h0000_0101, 32'h5555_AAAA, 4'd0,
              0, 0, 0, 0, 2'b00, 1, 4'b0000, 1'b0};
    tv[7] = '{0, 1'b1, 2'd1, 32'h0000_0200, 32'h0F0F_0F0F, 4'd0,
              0, 0, 2, 0, 2'b00, 1, 4'b0011, 1'b0};
    tv[8] = '{1, 1'b1, 2'd0, 32'h0000_0301, 32'h7777_8888, 4'd0,
              0, 0, 0, 0, 2'b00, 1, 4'b0010, 1'b0};

    for (int i = 0; i < 9; i++) begin
      c_ar_lat = tv[i].ar_lat; c_aw_lat = tv[i].aw_lat;
      c_w_lat = tv[i].w_lat; c_gap = tv[i].gap; c_b_lat = 1;
      c_rresp = tv[i].wr ? 2'b00 : tv[i].resp;
      c_bresp = tv[i].wr ? tv[i].resp : 2'b00;
      r = '{tv[i].wr, tv[i].size, tv[i].addr, tv[i].wdata, tv[i].len};
      m_last_beats = -1;
      m_last_strb = 4'hx;
      push(tv[i].port, r);
      run_idle("vec");
      chk("vec_beats", m_last_beats, tv[i].exp_beats);
      chk("vec_err", m_last_err, tv[i].exp_err);
      if (tv[i].wr) chk("vec_strb", m_last_strb, tv[i].exp_strb);
      tick();
    end

    // both ports requesting continuously: grants must alternate
    c_ar_lat = 1; c_aw_lat = 0; c_w_lat = 1; c_b_lat = 0; c_gap = 0;
    c_rresp = 0; c_bresp = 0;
    grant_log.delete();
    p0 = m_ptr;
    push(0, '{1'b0, 2'd2, 32'h100, 32'h0, 4'd1});
    push(0, '{1'b0, 2'd2, 32'h104, 32'h0, 4'd0});
    push(1, '{1'b1, 2'd2, 32'h200, 32'h1234, 4'd0});
    push(1, '{1'b1, 2'd0, 32'h201, 32'h5678, 4'd0});
    run_idle("rr");
    chk("rr_count", grant_log.size(), 4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++)
      chk("rr_grant", grant_log[i], (p0 + i) % NP);

    // reset in the middle of an 8-beat burst
    tick();
    c_gap = 0;
    push(0, '{1'b0, 2'd2, 32'h0000_4000, 32'h0, 4'd7});
    n = 0;
    while (!(m_busy && m_beats == 3) && n < 200) begin tick(); n++; end
    chk("mid_beats", m_beats, 3);
    @(negedge clk);
    #3;
    reset = 1;
    #1;
    chk_zero("midrst");
    clear_env();
    repeat (2) @(negedge clk);
    reset = 0;
    grant_log.delete();
    push(0, '{1'b0, 2'd2, 32'h0000_5000, 32'h0, 4'd0});
    push(1, '{1'b0, 2'd2, 32'h0000_6000, 32'h0, 4'd7});
    run_idle("post_rst");
    chk("post_cnt", grant_log.size(), 2);
    if (grant_log.size() == 2) begin
      chk("post_g0", grant_log[0], 0);
      chk("post_g1", grant_log[1], 1);
    end
    chk("post_beats", m_last_beats, 8);

    // randomized traffic
    for (int b = 0; b < 15; b++) begin
      c_ar_lat = $urandom_range(3); c_aw_lat = $urandom_range(3);
      c_w_lat = $urandom_range(3); c_b_lat = $urandom_range(2);
      c_gap = $urandom_range(50);
      c_rresp = ($urandom_range(3) == 0) ? 2'($urandom) : 2'b00;
      c_bresp = ($urandom_range(3) == 0) ? 2'($urandom) : 2'b00;
      n = $urandom_range(1, 4);
      for (int k = 0; k < n; k++) begin
        r.wr = 1'($urandom);
        r.size = 2'($urandom);
        r.addr = $urandom;
        r.wdata = $urandom;
        r.len = 4'($urandom);
        push($urandom_range(1), r);
      end
      run_idle("rand");
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_multiport_bridge.md
# axi_multiport_bridge

Parametrised successor to the single-pair sram-like→AXI3 bridge. It accepts sram-like requests from `N_PORTS` masters and arbitrates among them round-robin. It issues one AXI transaction at a time, with multi-beat INCR read bursts for cache refill and single-beat writes. It sits between the CPU-side request sources (I-fetch, D-access, refill engines) and the address-translating top-level AXI port.

## Interface
Parameters:
- `N_PORTS`, 2: number of sram-like masters; legal range 1..8.
- `LEN_W`, 4: width of the per-port read burst length field (beats−1).

Ports (clock and reset first; the clock is single; reset is asynchronous and active-high):
- `clk`  in  1  sole clock.
- `reset`  in  1  asynchronous, active-high reset.
- `req`  in  N_PORTS  per-port request.
- `wr`  in  N_PORTS  per-port write flag; 1 = write.
- `size`  in  2·N_PORTS  per-port size: 0 = byte, 1 = half, 2 = word.
- `addr`  in  32·N_PORTS  per-port byte address.
- `wdata`  in  32·N_PORTS  per-port write data, lane-aligned, passed unchanged.
- `len`  in  LEN_W·N_PORTS  per-port read beats−1; ignored for writes.
- `addr_ok`  out  N_PORTS  one-hot request-accepted pulse.
- `data_ok`  out  N_PORTS  one-hot beat/response pulse.
- `rdata`  out  32  shared read data, valid with `data_ok`.
- `rlast_o`  out  1  final read beat, valid with `data_ok`.
- `err`  out  1  response was non-OKAY, valid with `data_ok`.
- `arid/araddr/arlen/arsize/arburst/arlock/arcache/arprot/arvalid`  out  AXI3 AR channel, with `arready` in.
- `rid/rdata_axi/rresp/rlast/rvalid`  in  AXI3 R channel, with `rready` out.
- `awid/awaddr/awlen/awsize/awburst/awlock/awcache/awprot/awvalid`  out  AXI3 AW channel, with `awready` in.
- `wid/wdata_axi/wstrb/wlast/wvalid`  out  AXI3 W channel, with `wready` in.
- `bid/bresp/bvalid`  in  AXI3 B channel, with `bready` out.

## Operation
- FSM states: IDLE, AR, R, W, B.
- IDLE:
  - Round-robin grant among `req` bits, starting from pointer `ptr` (reset 0).
  - Winner k: `addr_ok[k]`=1 for that cycle. Latch wr/size/addr/wdata/len and k. Set `ptr`=(k+1) mod N_PORTS.
  - Next state is AR for a read, W for a write.
  - No `req` → stay in IDLE, `ptr` unchanged.
- AR:
  - `arvalid`=1. `arid`=k. `araddr`=addr. `arlen`=zero-extended len. `arsize`={0,size}. `arburst`=2'b01. `arlock`/`arcache`/`arprot`=0.
  - Hold all AR signals stable until `arvalid&arready`, then go to R.
- R:
  - `rready`=1.
  - Each `rvalid` cycle: `data_ok[k]`=1, `rdata`=`rdata_axi`, `rlast_o`=`rlast`, `err`=(`rresp`≠0). Path is combinational.
  - On `rvalid&rlast` → IDLE.
  - `rid` is not checked; only one transaction is ever outstanding.
- W:
  - On entry, `awvalid` and `wvalid` both =1. Each drops independently after its own handshake.
  - `awlen`=0, `wlast`=1, `awid`=`wid`=k.
  - When both handshakes are done (same cycle or different cycles) → B.
- wstrb:
  - size 0: 4'b0001<<addr[1:0].
  - size 1: 4'b0011<<{addr[1],1'b0}.
  - size 2: 4'b1111.
  - size 3: 4'b0000 (illegal encoding; transaction still completes).
- B: `bready`=1. On `bvalid`: `data_ok[k]`=1, `err`=(`bresp`≠0), then → IDLE.
- Requests arriving outside IDLE wait. Masters hold `req` until they see `addr_ok`.

## Timing
- Reset: all outputs 0, state IDLE, `ptr`=0. Any in-flight transaction is abandoned with no `data_ok`.
- Read latency: `addr_ok` cycle T, `arvalid` from T+1. Beat data_ok appears in the same cycle as the R handshake.
- Write: `awvalid`/`wvalid` from T+1. `data_ok` appears in the `bvalid` cycle.
- Back-to-back: after `data_ok` on the last beat, IDLE grants the next request in the following cycle. Turnaround is 1 idle cycle minimum.
- A `req` deasserted while in IDLE is simply not granted. A `req` deasserted mid-transaction has no effect.
- `addr_ok` and `data_ok` are never both high for the same port in one cycle.

## Structure
- Package `axi_bridge_pkg`:
  - state enum.
  - BURST_INCR=2'b01.
  - size codes.
  - RESP_OKAY=2'b00.
  - wstrb function.
- Sub-module `rr_arbiter` (params N): inputs `req`, `ptr`, `en`; outputs one-hot `gnt` and `gnt_idx`. The FSM owns `ptr`.

## Test plan
- Port 0 word read, addr 0x1FC0_0000, len 0; slave has `arready` 2 cycles late → `arid`=0, `arlen`=0, `arsize`=2. A single `data_ok[0]` with `rlast_o`=1, `err`=0.
- Port 1 refill read, len 7, addr 0x0000_1000; slave inserts `rvalid` gaps → exactly 8 `data_ok[1]` pulses in order, `rlast_o` only on the 8th, `arburst`=01.
- Port 0 byte write to addr 0x…3, then half write to 0x…2 → `wstrb`=1000, then 1100, `awlen`=0, `wlast`=1. `wready` precedes `awready` by 3 cycles and the bridge still reaches B.
- `req`=2'b11 held continuously for 4 transactions with N_PORTS=2 → grants alternate 0,1,0,1.
- `bresp`=2'b10 on a write and `rresp`=2'b11 on a read → `err`=1 alongside the respective `data_ok`.
- Reset asserted mid-R burst (beat 3 of 8) → all outputs 0 immediately. After release, a new read from port 1 completes normally with `ptr` restarting from 0.
